// File: rtl/stoch_pkg.sv
// Shared constants and width helpers for the stochastic bitstream blocks.
package stoch_pkg;

  // Channel count used when a block is instantiated without overrides;
  // the averager's reset divisor defaults to the same value.
  localparam int DEFAULT_NUM_POPS = 4;
  localparam int DEFAULT_DIV_C    = DEFAULT_NUM_POPS;

  // Smallest bit count r (at least 1) such that 2**r >= v.
  function automatic int clog2_w(input longint v);
    int r;
    r = 0;
    while ((longint'(1) << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Largest weighted sum when every channel fires with the maximum weight.
  function automatic int max_wsum(input int num_pops, input int weight_w);
    return num_pops * ((1 << weight_w) - 1);
  endfunction

  // Highest accumulator value that still cannot wrap on the next add.
  function automatic longint sat_bound(input int acc_w, input int num_pops,
                                       input int weight_w);
    return (longint'(1) << acc_w) - 1 - longint'(max_wsum(num_pops, weight_w));
  endfunction

endpackage

// File: rtl/stoch_wsum.sv
// Weighted popcount: sums the fixed per-channel weights of the asserted bits.
module stoch_wsum
  import stoch_pkg::*;
#(
  parameter int NUM_POPS = DEFAULT_NUM_POPS,
  parameter int WEIGHT_W = 2,
  parameter logic [NUM_POPS*WEIGHT_W-1:0] WEIGHTS = {NUM_POPS{WEIGHT_W'(1)}},
  parameter int SUM_W    = clog2_w(longint'(max_wsum(NUM_POPS, WEIGHT_W)) + 1)
) (
  input  logic [NUM_POPS-1:0] a,
  output logic [SUM_W-1:0]    wsum
);

  // Accumulate each active channel's weight; synthesis balances the adders.
  always_comb begin
    wsum = '0;
    for (int i = 0; i < NUM_POPS; i++) begin
      if (a[i]) wsum = wsum + SUM_W'(WEIGHTS[i*WEIGHT_W +: WEIGHT_W]);
    end
  end

endmodule

// File: rtl/stoch_wavg.sv
// Weighted, runtime-scalable averager for unipolar stochastic bitstreams.
// Optional macro STOCH_WAVG_OUTREG_EN registers y (one cycle of latency).
module stoch_wavg
  import stoch_pkg::*;
#(
  parameter int NUM_POPS    = DEFAULT_NUM_POPS,
  parameter int WEIGHT_W    = 2,
  parameter logic [NUM_POPS*WEIGHT_W-1:0] WEIGHTS = {NUM_POPS{WEIGHT_W'(1)}},
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = NUM_POPS,
  parameter int ACC_W       = DIV_W + 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                en,
  input  logic [NUM_POPS-1:0] a,
  input  logic                div_ld,
  input  logic [DIV_W-1:0]    div_in,
  output logic                y,
  output logic [DIV_W-1:0]    div_q,
  output logic                sat
);

  localparam int SUM_W = clog2_w(longint'(max_wsum(NUM_POPS, WEIGHT_W)) + 1);
  localparam logic [ACC_W-1:0] SAT_BOUND = ACC_W'(sat_bound(ACC_W, NUM_POPS, WEIGHT_W));

  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] wsum;
  logic [ACC_W-1:0] new_acc;
  logic [ACC_W-1:0] acc_sub;
  logic             hit;
  logic             over;
  logic             ld_ok;
  logic             y_comb;

  stoch_wsum #(
    .NUM_POPS (NUM_POPS),
    .WEIGHT_W (WEIGHT_W),
    .WEIGHTS  (WEIGHTS),
    .SUM_W    (SUM_W)
  ) u_wsum (
    .a    (a),
    .wsum (wsum)
  );

  // Add this cycle's weights, emit a 1 when the divisor is reached and
  // flag results that would leave too little headroom for the next add.
  always_comb begin
    ld_ok   = div_ld && (div_in != '0);
    new_acc = acc + ACC_W'(wsum);
    hit     = (new_acc >= ACC_W'(div_q));
    acc_sub = hit ? (new_acc - ACC_W'(div_q)) : new_acc;
    over    = (acc_sub > SAT_BOUND);
    y_comb  = en && !ld_ok && hit;
  end

  // A divisor load starts a new epoch and outranks accumulation.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      acc   <= '0;
      div_q <= DIV_W'(DEFAULT_DIV);
      sat   <= 1'b0;
    end else if (ld_ok) begin
      acc   <= '0;
      div_q <= div_in;
      sat   <= 1'b0;
    end else if (en) begin
      acc <= over ? SAT_BOUND : acc_sub;
      if (over) sat <= 1'b1;
    end
  end

`ifdef STOCH_WAVG_OUTREG_EN
  logic y_q;

  // Retime the output to cut the combinational path from a to y.
  always_ff @(posedge CLK) begin
    if (!nRST) y_q <= 1'b0;
    else       y_q <= y_comb;
  end

  assign y = y_q;
`else
  assign y = y_comb;
`endif

endmodule

// File: doc/stoch_wavg.md
Name: stoch_wavg

Overview:
Weighted, runtime-scalable averager for unipolar stochastic bitstreams. Each cycle it adds the per-channel integer weights of the asserted input bits into a residue accumulator. When the accumulator reaches the programmable divisor, it emits a 1 and subtracts the divisor. Output probability is sum(w_i * p_i) / div. It is the general form of the fixed N-input averager and sits between stochastic multiplier/adder stages in datapaths.

Parameters:
NUM_POPS, 4, number of input bitstreams (>= 2)
WEIGHT_W, 2, width of each channel weight
WEIGHTS, {NUM_POPS{2'd1}}, packed per-channel weights; channel i is WEIGHTS[i*WEIGHT_W +: WEIGHT_W]
DIV_W, 8, divisor register width
DEFAULT_DIV, NUM_POPS, divisor value after reset (nonzero, < 2**DIV_W)
ACC_W, DIV_W+2, accumulator width; must hold 2**DIV_W - 1 + NUM_POPS*(2**WEIGHT_W - 1)

Ports:
CLK  input  1  clock
nRST  input  1  synchronous active-low reset
en  input  1  advance enable; low holds all state
a  input  NUM_POPS  input bitstreams, one bit per channel
div_ld  input  1  load strobe for div_in
div_in  input  DIV_W  new divisor
y  output  1  averaged bitstream (combinational from acc and a)
div_q  output  DIV_W  current divisor
sat  output  1  sticky accumulator-saturation flag

Behaviour:
- Reset and interface: reset nRST, synchronous, active-low; clock CLK.
- On reset:
  - acc = 0, div_q = DEFAULT_DIV, sat = 0.
  - y follows its combinational equation, so it is 0 while en=0.
- Weighted sum:
  - wsum = sum over i of (a[i] ? w_i : 0), computed combinationally, zero-extended to ACC_W.
  - Same-cycle, zero latency.
- new_acc = acc + wsum.
- When en=1 and div_ld=0:
  - y = (new_acc >= div_q).
  - acc_next = y ? new_acc - div_q : new_acc.
- Saturation (en=1):
  - If acc_next > 2**ACC_W - 1 - NUM_POPS*(2**WEIGHT_W - 1), clamp acc to that bound and set sat=1.
  - sat stays set until reset or an accepted div_ld.
  - The bound guarantees no wrap on the next add.
- When en=0: y = 0; acc, sat and div_q hold. Inputs on that cycle are dropped, not deferred.
- div_ld=1 with div_in != 0:
  - Next cycle: div_q = div_in, acc = 0, sat = 0.
  - y = 0 on the load cycle regardless of en (new epoch; residue discarded).
- div_ld=1 with div_in == 0: load ignored; normal en behaviour applies that cycle.
- Simultaneous en=1 and an accepted div_ld: the load wins as above, and the weights are not accumulated.
- Steady state (no saturation):
  - acc < div_q after every update.
  - y can be 1 on at most one cycle per update, so the ratio is exact when sum(w_i*p_i) <= div_q.
  - Above that, the output clips to 1 and sat eventually asserts.
- Reset mid-stream: acc and sat are cleared and the divisor returns to DEFAULT_DIV on the next edge. No residual output.
- Arithmetic is unsigned throughout. The comparison is performed at ACC_W width with div_q zero-extended.

Optional Feature:
- Macro: STOCH_WAVG_OUTREG_EN
- Defined:
  - y is registered: y_q <= y_comb each edge where nRST=1; y_q = 0 on reset.
  - Output latency is 1 cycle; accumulator behaviour is unchanged. This breaks the combinational path from a to y for timing closure.
- Undefined: y is combinational, zero latency, as specified above.

Decomposition:
- Package stoch_pkg:
  - clog2-style width helper.
  - Function computing max weighted sum from NUM_POPS/WEIGHT_W.
  - Localparam formula for the saturation bound.
  - Default-divisor constant.
- Sub-module stoch_wsum:
  - Parameterised combinational weighted popcount (adder tree) over a with WEIGHTS.
  - Output width clog2(NUM_POPS*(2**WEIGHT_W - 1) + 1).
  - Instantiated once; reusable by other stochastic adders.

Test Plan:
1. Defaults (weights 1, div 4). Input streams:
   - a=4'b1111 constantly, en=1 -> y=1 every cycle, acc stays 0.
   - a=4'b0011 -> y pattern 0,1,0,1, acc alternates 2,0.
2. WEIGHTS={1,1,2,3} with channel 3 weight 3, div 6, a=4'b1000 for 6 cycles -> y=0,1,0,1,0,1; acc 3,0,3,0,3,0.
3. div_ld with div_in=10 while acc=3 and en=1 -> y=0 that cycle; next cycle div_q=10, acc=0. div_ld with div_in=0 -> div_q unchanged, normal accumulation.
4. Saturation at weights 3, div 1, ACC_W=4: a=4'b1111 for 20 cycles.
   - Derived bound is 15-12=3; each update gives acc=min(acc+11, 3)=3, so acc clamps from the first cycle and sat rises after cycle 1.
   - y=1 every cycle; acc never wraps.
   - Then div_ld with div_in=8 -> sat=0, acc=0.
5. en=0 for 5 cycles with a=4'b1111 -> y=0, acc and div_q unchanged. nRST=0 mid-run with acc=3 -> acc=0, div_q=4, sat=0 next cycle.
6. STOCH_WAVG_OUTREG_EN defined: rerun scenario 1 -> identical y sequence delayed 1 cycle; y=0 on the cycle after reset.
